// File: rtl/router_input_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : router_input_ctrl_if
//  Description : Handshake/bus bundle of one router input port. The link side
//                is send_in/data_in/ready_in; the output-controller side is
//                req/data_out/clear.
//  Revision    : 1.0 - initial release
// ============================================================================
interface router_input_ctrl_if #(
  parameter int DATA_W = 64
) ();
  logic              send_in;
  logic [DATA_W-1:0] data_in;
  logic              ready_in;
  logic [4:0]        req;
  logic [DATA_W-1:0] data_out;
  logic [4:0]        clear;

  // Upstream link plus the output controllers (environment side)
  modport master (
    output send_in, data_in, clear,
    input  ready_in, req, data_out
  );

  // The input controller itself
  modport slave (
    input  send_in, data_in, clear,
    output ready_in, req, data_out
  );
endinterface
`default_nettype wire

// File: rtl/router_input_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : router_input_ctrl
//  Description : Per-port ingress stage of the mesh router. Two virtual-channel
//                buffers alternate between receiving from the link and
//                presenting to the output controllers, selected by the
//                router-wide polarity. XY route is computed on write and the
//                consumed hop field is decremented.
//  Revision    : 1.0 - initial release
// ============================================================================
module router_input_ctrl #(
  parameter int DATA_W = 64,
  parameter int HOP_W  = 4,
  parameter int CNT_W  = 16
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             polarity,
  router_input_ctrl_if.slave    bus,
  output logic                  vc_err,
  output logic [CNT_W-1:0]      pkt_cnt
);

  // Header field positions, counted down from the MSB
  localparam int VC_BIT   = DATA_W - 1;
  localparam int XDIR_BIT = DATA_W - 2;
  localparam int YDIR_BIT = DATA_W - 3;
  localparam int HX_LSB   = DATA_W - 4 - HOP_W;
  localparam int HY_LSB   = HX_LSB - HOP_W;

  // One-hot output requests, same bit order as clear
  localparam logic [4:0] R_PE = 5'b00001;
  localparam logic [4:0] R_S  = 5'b00010;
  localparam logic [4:0] R_N  = 5'b00100;
  localparam logic [4:0] R_E  = 5'b01000;
  localparam logic [4:0] R_W  = 5'b10000;

  logic              link_vc;
  logic              int_vc;
  logic [HOP_W-1:0]  hx_in;
  logic [HOP_W-1:0]  hy_in;
  logic [4:0]        route_in;
  logic [DATA_W-1:0] routed_in;
  logic              accept;
  logic              wrong_vc;
  logic              release_int;

  logic [DATA_W-1:0] storage_q [2];
  logic [DATA_W-1:0] storage_d [2];
  logic [4:0]        route_q   [2];
  logic [4:0]        route_d   [2];
  logic [1:0]        valid_q;
  logic [1:0]        valid_d;
  logic              vc_err_q;
  logic              vc_err_d;
  logic [CNT_W-1:0]  pkt_cnt_q;
  logic [CNT_W-1:0]  pkt_cnt_d;

  // Link VC receives, the other VC forwards internally
  assign link_vc = ~polarity;
  assign int_vc  = polarity;

  assign hx_in = bus.data_in[HX_LSB +: HOP_W];
  assign hy_in = bus.data_in[HY_LSB +: HOP_W];

  // XY routing of the incoming packet: X first, then Y, then eject to PE
  always_comb begin
    routed_in = bus.data_in;
    route_in  = R_PE;
    if (hx_in != '0) begin
      route_in                  = bus.data_in[XDIR_BIT] ? R_W : R_E;
      routed_in[HX_LSB +: HOP_W] = hx_in - HOP_W'(1);
    end else if (hy_in != '0) begin
      route_in                  = bus.data_in[YDIR_BIT] ? R_S : R_N;
      routed_in[HY_LSB +: HOP_W] = hy_in - HOP_W'(1);
    end
  end

  assign accept      = bus.send_in && !valid_q[link_vc] && (bus.data_in[VC_BIT] == link_vc);
  assign wrong_vc    = bus.send_in && (bus.data_in[VC_BIT] != link_vc);
  assign release_int = valid_q[int_vc] && ((bus.clear & route_q[int_vc]) != 5'b00000);

  // Next-state for both VC buffers, the error flag and the counter.
  // Accept and release always target different buffers, so both may fire.
  always_comb begin
    storage_d = storage_q;
    route_d   = route_q;
    valid_d   = valid_q;
    vc_err_d  = vc_err_q;
    pkt_cnt_d = pkt_cnt_q;

    if (release_int) begin
      valid_d[int_vc]   = 1'b0;
      storage_d[int_vc] = '0;
    end

    if (accept) begin
      valid_d[link_vc]   = 1'b1;
      storage_d[link_vc] = routed_in;
      route_d[link_vc]   = route_in;
      if (pkt_cnt_q != '1) begin
        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
      end
    end

    if (wrong_vc) begin
      vc_err_d = 1'b1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      storage_q <= '{default: '0};
      route_q   <= '{default: '0};
      valid_q   <= '0;
      vc_err_q  <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      storage_q <= storage_d;
      route_q   <= route_d;
      valid_q   <= valid_d;
      vc_err_q  <= vc_err_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  // Only the internally active VC is visible to the output controllers
  assign bus.ready_in = ~valid_q[link_vc];
  assign bus.req      = valid_q[int_vc] ? route_q[int_vc] : 5'b00000;
  assign bus.data_out = valid_q[int_vc] ? storage_q[int_vc] : '0;
  assign vc_err       = vc_err_q;
  assign pkt_cnt      = pkt_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_router_input_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_router_input_ctrl
//  Description : Self-checking bench for router_input_ctrl. A buffer-level
//                model tracks what each VC holds; outputs are compared on
//                every falling edge, plus directed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_router_input_ctrl;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             polarity;
  logic             vc_err;
  logic [CNT_W-1:0] pkt_cnt;

  router_input_ctrl_if #(.DATA_W(DATA_W)) bus ();

  router_input_ctrl #(.DATA_W(DATA_W), .HOP_W(4), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .polarity (polarity),
    .bus      (bus),
    .vc_err   (vc_err),
    .pkt_cnt  (pkt_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state: what each buffer holds and where it is going
  bit          m_valid [2];
  logic [63:0] m_data  [2];
  logic [4:0]  m_route [2];
  bit          m_err;
  int          m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk(input bit vc, input bit xd, input bit yd,
                                     input logic [3:0] hx, input logic [3:0] hy,
                                     input logic [51:0] pl);
    return {vc, xd, yd, 1'b0, hx, hy, pl};
  endfunction

  // Destination port from the hop counts: X is consumed before Y
  function automatic logic [4:0] route_of(input logic [63:0] d);
    if (d[59:56] != 0) return d[62] ? 5'b10000 : 5'b01000;
    if (d[55:52] != 0) return d[61] ? 5'b00010 : 5'b00100;
    return 5'b00001;
  endfunction

  function automatic logic [63:0] fwd_of(input logic [63:0] d);
    logic [63:0] r;
    r = d;
    if (d[59:56] != 0)      r[59:56] = d[59:56] - 4'd1;
    else if (d[55:52] != 0) r[55:52] = d[55:52] - 4'd1;
    return r;
  endfunction

  // Model update on each rising edge
  always @(posedge clk) begin
    int  l, i;
    bit  rel, acc;
    if (reset) begin
      m_valid = '{0, 0};
      m_data  = '{64'd0, 64'd0};
      m_route = '{5'd0, 5'd0};
      m_err   = 0;
      m_cnt   = 0;
    end else begin
      l   = polarity ? 0 : 1;
      i   = polarity ? 1 : 0;
      rel = m_valid[i] && ((bus.clear & m_route[i]) != 0);
      acc = bus.send_in && !m_valid[l] && (bus.data_in[63] == l[0]);
      if (bus.send_in && bus.data_in[63] != l[0]) m_err = 1;
      if (rel) begin
        m_valid[i] = 0;
        m_data[i]  = 64'd0;
      end
      if (acc) begin
        m_valid[l] = 1;
        m_data[l]  = fwd_of(bus.data_in);
        m_route[l] = route_of(bus.data_in);
        if (m_cnt < 65535) m_cnt++;
      end
    end
  end

  // Output comparison on every falling edge
  always @(negedge clk) begin
    int i, l;
    if (chk_en) begin
      i = polarity ? 1 : 0;
      l = 1 - i;
      check("ready_in", {63'd0, bus.ready_in}, {63'd0, !m_valid[l]});
      check("req", {59'd0, bus.req}, m_valid[i] ? {59'd0, m_route[i]} : 64'd0);
      check("data_out", bus.data_out, m_valid[i] ? m_data[i] : 64'd0);
      check("vc_err", {63'd0, vc_err}, {63'd0, m_err});
      check("pkt_cnt", {48'd0, pkt_cnt}, 64'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [63:0] pkt;

  initial begin
    reset        = 1'b1;
    polarity     = 1'b0;
    bus.send_in  = 1'b0;
    bus.data_in  = '0;
    bus.clear    = '0;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rst_ready", {63'd0, bus.ready_in}, 64'd1);
    check("rst_req", {59'd0, bus.req}, 64'd0);

    // X route east, hx 2 -> 1
    pkt = mk(1'b1, 1'b0, 1'b0, 4'd2, 4'd0, 52'h0_1234_5678_9ABC);
    bus.send_in = 1'b1; bus.data_in = pkt; #1;
    check("t1_ready_before", {63'd0, bus.ready_in}, 64'd1);
    tick();
    bus.send_in = 1'b0; #1;
    check("t1_ready_after", {63'd0, bus.ready_in}, 64'd0);
    polarity = 1'b1; #1;
    check("t1_req", {59'd0, bus.req}, 64'h08);
    check("t1_hx", {60'd0, bus.data_out[59:56]}, 64'd1);
    check("t1_data", bus.data_out, 64'h8100_1234_5678_9ABC);

    // Clear on an unrequested bit is ignored, matching bit releases
    bus.clear = 5'b00001;
    tick();
    check("t3_hold", {59'd0, bus.req}, 64'h08);
    bus.clear = 5'b01000;
    tick();
    bus.clear = 5'b00000; #1;
    check("t3_req_rel", {59'd0, bus.req}, 64'd0);
    check("t3_data_rel", bus.data_out, 64'd0);

    // Y route south, hy 3 -> 2 (polarity 1: link VC is 0)
    pkt = mk(1'b0, 1'b0, 1'b1, 4'd0, 4'd3, 52'h5_5555_AAAA_0F0F);
    bus.send_in = 1'b1; bus.data_in = pkt;
    tick();
    bus.send_in = 1'b0; polarity = 1'b0; #1;
    check("t2_req_s", {59'd0, bus.req}, 64'h02);
    check("t2_hy", {60'd0, bus.data_out[55:52]}, 64'd2);
    bus.clear = 5'b00010;
    tick();
    bus.clear = 5'b00000;

    // Eject to PE, packet unchanged (polarity 0: link VC is 1)
    pkt = mk(1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 52'hF_EDCB_A987_6543);
    bus.send_in = 1'b1; bus.data_in = pkt;
    tick();
    bus.send_in = 1'b0; polarity = 1'b1; #1;
    check("t2_req_pe", {59'd0, bus.req}, 64'h01);
    check("t2_data_pe", bus.data_out, pkt);
    bus.clear = 5'b00001;
    tick();
    bus.clear = 5'b00000;

    // Wrong VC: offered on VC 0 while the link VC is 1
    polarity = 1'b0;
    bus.send_in = 1'b1; bus.data_in = mk(1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 52'h1);
    tick();
    bus.send_in = 1'b0; #1;
    check("t4_err", {63'd0, vc_err}, 64'd1);
    check("t4_cnt", {48'd0, pkt_cnt}, 64'd3);
    check("t4_ready", {63'd0, bus.ready_in}, 64'd1);
    tick(); tick();
    check("t4_err_sticky", {63'd0, vc_err}, 64'd1);

    // Fill both VCs: VC1 routes W, VC0 routes N
    polarity = 1'b0;
    bus.send_in = 1'b1; bus.data_in = mk(1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 52'h111);
    tick();
    polarity = 1'b1;
    bus.data_in = mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 52'h222);
    tick();
    bus.send_in = 1'b0;
    for (int k = 0; k < 10; k++) begin
      polarity = k[0]; #1;
      check("t5_ready", {63'd0, bus.ready_in}, 64'd0);
      check("t5_req", {59'd0, bus.req}, k[0] ? 64'h10 : 64'h04);
      tick();
    end
    check("t5_cnt", {48'd0, pkt_cnt}, 64'd5);

    // Reset with both VCs full
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    check("t6_req", {59'd0, bus.req}, 64'd0);
    check("t6_ready", {63'd0, bus.ready_in}, 64'd1);
    check("t6_cnt", {48'd0, pkt_cnt}, 64'd0);
    check("t6_err", {63'd0, vc_err}, 64'd0);

    // Stream one packet per cycle with full clears to saturate the counter
    for (int k = 0; k < 65540; k++) begin
      polarity    = k[0];
      bus.send_in = 1'b1;
      bus.data_in = {$urandom, $urandom};
      bus.data_in[63] = ~k[0];
      bus.clear   = 5'b11111;
      tick();
    end
    bus.send_in = 1'b0;
    bus.clear   = 5'b00000;
    #1;
    check("t7_cnt_sat", {48'd0, pkt_cnt}, 64'h0000_0000_0000_FFFF);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
